alu_seq_param: RTL and testbench

ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

---
 rtl/alu_seq_param.sv | 262 ++++++++++++++++++++++++++
 tb/tb_alu_seq_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// alu_seq_param: sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD, SUB, GT, EQ, LT, AND, OR, XOR, SLL, SRL) finish in
// one cycle. MUL is an iterative shift-add multiplier that is built only
// when the macro ALU_SEQ_PARAM_MUL_EN is defined. Without that macro,
// op 8 is treated as an illegal opcode.
// Results and flags are held in registers and stay stable while
// out_valid && !out_ready.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             err_flag
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef ALU_SEQ_PARAM_MUL_EN
  localparam logic [1:0] ST_BUSY = 2'd1;
`endif
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_GT  = 4'd2;
  localparam logic [3:0] OP_EQ  = 4'd3;
  localparam logic [3:0] OP_LT  = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
`ifdef ALU_SEQ_PARAM_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
`endif
  localparam logic [3:0] OP_SLL = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;

  logic [1:0]       state_q,     state_d;
  logic             valid_q,     valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q,      zero_d;
  logic             carry_q,     carry_d;
  logic             ovf_q,       ovf_d;
  logic             err_q,       err_d;

  logic             accept_s;
  logic [WIDTH-1:0] sc_res_s;
  logic             sc_carry_s;
  logic             sc_ovf_s;
  logic             sc_err_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [SHW-1:0]   sh_s;
  logic [2*WIDTH-1:0] sll_ext_s;
  logic [2*WIDTH-1:0] srl_ext_s;

`ifdef ALU_SEQ_PARAM_MUL_EN
  localparam int CNTW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] prod_q,  prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNTW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
`endif

  assign accept_s   = in_valid && in_ready;
  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid  = valid_q;
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign ovf_flag   = ovf_q;
  assign err_flag   = err_q;

  assign add_s     = {1'b0, a} + {1'b0, b};
  assign sub_s     = {1'b0, a} - {1'b0, b};
  assign sh_s      = b[SHW-1:0];
  assign sll_ext_s = {{WIDTH{1'b0}}, a} << sh_s;
  assign srl_ext_s = {a, {WIDTH{1'b0}}} >> sh_s;

  // Single-cycle datapath: result and flags for every non-MUL opcode.
  always_comb begin
    sc_res_s   = {WIDTH{1'b0}};
    sc_carry_s = 1'b0;
    sc_ovf_s   = 1'b0;
    sc_err_s   = 1'b0;
    case (op_code)
      OP_ADD: begin
        sc_res_s   = add_s[WIDTH-1:0];
        sc_carry_s = add_s[WIDTH];
        sc_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res_s   = sub_s[WIDTH-1:0];
        sc_carry_s = (a < b);
        sc_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_GT:  sc_res_s = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:  sc_res_s = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_LT:  sc_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_AND: sc_res_s = a & b;
      OP_OR:  sc_res_s = a | b;
      OP_XOR: sc_res_s = a ^ b;
      OP_SLL: begin
        sc_res_s   = sll_ext_s[WIDTH-1:0];
        sc_carry_s = (sh_s != {SHW{1'b0}}) ? sll_ext_s[WIDTH] : 1'b0;
      end
      OP_SRL: begin
        sc_res_s   = srl_ext_s[2*WIDTH-1:WIDTH];
        sc_carry_s = (sh_s != {SHW{1'b0}}) ? srl_ext_s[WIDTH-1] : 1'b0;
      end
      default: sc_err_s = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_PARAM_MUL_EN
  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit (the LSB of the product register) is set, then
  // shift right.
  always_comb begin
    mul_sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                 (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, prod_q[WIDTH-1:1]};
  end
`endif

  // Next-state logic for the FSM, the result/flag registers and the multiplier.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
`ifdef ALU_SEQ_PARAM_MUL_EN
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
`endif
    if (accept_s) begin
`ifdef ALU_SEQ_PARAM_MUL_EN
      if (op_code == OP_MUL) begin
        state_d = ST_BUSY;
        valid_d = 1'b0;
        prod_d  = {{WIDTH{1'b0}}, b};
        mcand_d = a;
        cnt_d   = {CNTW{1'b0}};
      end else begin
        state_d     = ST_DONE;
        valid_d     = 1'b1;
        result_d    = sc_res_s;
        result_hi_d = {WIDTH{1'b0}};
        zero_d      = (sc_res_s == {WIDTH{1'b0}});
        carry_d     = sc_carry_s;
        ovf_d       = sc_ovf_s;
        err_d       = sc_err_s;
      end
`else
      state_d     = ST_DONE;
      valid_d     = 1'b1;
      result_d    = sc_res_s;
      result_hi_d = {WIDTH{1'b0}};
      zero_d      = (sc_res_s == {WIDTH{1'b0}});
      carry_d     = sc_carry_s;
      ovf_d       = sc_ovf_s;
      err_d       = sc_err_s;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
`ifdef ALU_SEQ_PARAM_MUL_EN
        ST_BUSY: begin
          prod_d = mul_next_s;
          cnt_d  = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
          if (cnt_q == CNTW'(WIDTH-1)) begin
            state_d     = ST_DONE;
            valid_d     = 1'b1;
            result_d    = mul_next_s[WIDTH-1:0];
            result_hi_d = mul_next_s[2*WIDTH-1:WIDTH];
            zero_d      = (mul_next_s == {(2*WIDTH){1'b0}});
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            err_d       = 1'b0;
          end else begin
            state_d = ST_BUSY;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, result and flag registers; reset clears every visible output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

`ifdef ALU_SEQ_PARAM_MUL_EN
  // Multiplier working registers; reset drops any in-flight product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= {(2*WIDTH){1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      cnt_q   <= {CNTW{1'b0}};
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param (WIDTH=8): directed corner cases
// followed by randomized operations against a plain-arithmetic reference model.
module tb_alu_seq_param;

  localparam int W = 8;
`ifdef ALU_SEQ_PARAM_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op_code = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero_flag, carry_flag, ovf_flag, err_flag;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    longint res;
    longint hi;
    longint z;
    longint c;
    longint o;
    longint e;
    int     lat;
  } exp_t;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_code(op_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .ovf_flag(ovf_flag), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint to_signed(input longint v);
    return (v >= (64'sd1 << (W-1))) ? v - (64'sd1 << W) : v;
  endfunction

  // Reference model computed from the operation definitions with integer math.
  function automatic exp_t model(input int op, input longint av, input longint bv);
    exp_t   e;
    longint m, s, sh;
    m = (64'sd1 << W) - 1;
    e.res = 0; e.hi = 0; e.c = 0; e.o = 0; e.e = 0; e.lat = 1;
    sh = bv % W;
    case (op)
      0: begin
        s = av + bv; e.res = s & m; e.c = (s > m) ? 1 : 0;
        s = to_signed(av) + to_signed(bv);
        e.o = (s > m/2 || s < -(m/2) - 1) ? 1 : 0;
      end
      1: begin
        s = av - bv; e.res = s & m; e.c = (av < bv) ? 1 : 0;
        s = to_signed(av) - to_signed(bv);
        e.o = (s > m/2 || s < -(m/2) - 1) ? 1 : 0;
      end
      2: e.res = (av > bv) ? 1 : 0;
      3: e.res = (av == bv) ? 1 : 0;
      4: e.res = (av < bv) ? 1 : 0;
      5: e.res = av & bv;
      6: e.res = av | bv;
      7: e.res = av ^ bv;
      8: begin
        if (MUL_EN) begin
          s = av * bv; e.res = s & m; e.hi = (s >> W) & m; e.lat = W + 1;
        end else begin
          e.e = 1;
        end
      end
      9: begin
        e.res = (av << sh) & m;
        e.c = (sh == 0) ? 0 : ((av >> (W - sh)) & 1);
      end
      10: begin
        e.res = av >> sh;
        e.c = (sh == 0) ? 0 : ((av >> (sh - 1)) & 1);
      end
      default: e.e = 1;
    endcase
    e.z = (e.res == 0 && e.hi == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".result"},    result,     e.res);
    chk({tag, ".result_hi"}, result_hi,  e.hi);
    chk({tag, ".zero"},      zero_flag,  e.z);
    chk({tag, ".carry"},     carry_flag, e.c);
    chk({tag, ".ovf"},       ovf_flag,   e.o);
    chk({tag, ".err"},       err_flag,   e.e);
  endtask

  // One transaction from IDLE: accept, wait for the result, hold it for
  // 'hold' cycles with out_ready low, then pop it.
  task automatic run_op(input string tag, input int op, input int av, input int bv, input int hold);
    exp_t e;
    int   lat;
    e = model(op, av, bv);
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; op_code = op[3:0]; a = av[W-1:0]; b = bv[W-1:0]; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; op_code = $urandom;
    lat = 1;
    while (!out_valid && lat <= W + 4) begin
      chk({tag, ".busy_in_ready"}, in_ready, 0);
      in_valid = $urandom_range(0, 1);
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, e.lat);
    check_outs(tag, e);
    repeat (hold) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; op_code = $urandom;
      @(negedge clk);
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_in_ready"}, in_ready, 0);
      check_outs({tag, ".hold"}, e);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".pop"}, out_valid, 0);
  endtask

  task automatic check_zeroed(input string tag);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".result"}, result, 0);
    chk({tag, ".result_hi"}, result_hi, 0);
    chk({tag, ".flags"}, {zero_flag, carry_flag, ovf_flag, err_flag}, 0);
  endtask

  initial begin
    exp_t e;
    // Reset state
    #2;
    check_zeroed("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready", in_ready, 1);

    // Directed corner cases
    run_op("add_ff_01", 0, 8'hFF, 8'h01, 0);
    run_op("sub_80_01", 1, 8'h80, 8'h01, 1);
    run_op("mul_ff_ff", 8, 8'hFF, 8'hFF, 0);
    run_op("illegal12", 12, 8'h12, 8'h00, 0);
    run_op("op8", 8, 8'h12, 8'h34, 0);
    run_op("sll_by0", 9, 8'hA5, 8'h08, 0);
    run_op("srl_by7", 10, 8'h80, 8'h07, 0);
    run_op("sll_by1", 9, 8'h80, 8'h01, 0);

    // Back-to-back AND then XOR at full throughput, then a 3-cycle stall
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; op_code = 4'd5; a = 8'hF0; b = 8'h3C;
    @(negedge clk);
    chk("b2b.valid1", out_valid, 1);
    check_outs("b2b.and", model(5, 8'hF0, 8'h3C));
    chk("b2b.in_ready", in_ready, 1);
    op_code = 4'd7; a = 8'hAA; b = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b.valid2", out_valid, 1);
    e = model(7, 8'hAA, 8'hAA);
    check_outs("b2b.xor", e);
    repeat (3) begin
      in_valid = 1'b1; op_code = 4'd0; a = $urandom; b = $urandom;
      @(negedge clk);
      chk("b2b.stall_in_ready", in_ready, 0);
      chk("b2b.stall_valid", out_valid, 1);
      check_outs("b2b.stall", e);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("b2b.pop", out_valid, 0);

    // Reset in the middle of a MUL (or while holding a result without MUL)
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0; op_code = MUL_EN ? 4'd8 : 4'd0; a = 8'hFF; b = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zeroed("midrst");
    @(negedge clk);
    check_zeroed("midrst.hold");
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("midrst.in_ready", in_ready, 1);
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("midrst.no_stale", out_valid, 0);
    end

    // Randomized operations
    for (int i = 0; i < 300; i++) begin
      int op;
      op = (i % 5 == 0) ? 8 : $urandom_range(0, 15);
      run_op("rand", op, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
